// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the select of a 31-input selection mux.
// Grants one enabled requester at a time, with a watchdog for stalled consumers.
module mux_rr_sched #(
  parameter int N       = 31,
  parameter int SELW    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    en_mask,
  input  logic            ready,
  input  logic            clr_err,
  output logic [SELW-1:0] sel,
  output logic [N-1:0]    grant,
  output logic            out_valid,
  output logic [N-1:0]    ack,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [SELW-1:0] ptr;
  logic [7:0]      wd;
  logic [N-1:0]    cand;
  logic [SELW-1:0] base;
  logic [SELW-1:0] win;
  logic            found;
  logic            expire;
  logic            rel;

  function automatic logic [SELW-1:0] wrap(input logic [SELW:0] v);
    logic [SELW:0] lim;
    lim = (SELW+1)'(N);
    if (v >= lim) return SELW'(v - lim);
    return SELW'(v);
  endfunction

  assign expire = (wd == 8'(TIMEOUT - 1));
  assign rel    = (state == GRANT) && (ready || expire);

  // Rotating-priority search; the current grant is masked off on re-arbitration
  always_comb begin
    cand  = req & en_mask;
    base  = ptr;
    if (state == GRANT) begin
      cand = cand & ~grant;
      base = sel;
    end
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= N; off++) begin
      if (!found && cand[wrap({1'b0, base} + (SELW+1)'(off))]) begin
        found = 1'b1;
        win   = wrap({1'b0, base} + (SELW+1)'(off));
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: leave GRANT only on a release with nobody waiting
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (found) state_nx = GRANT;
      GRANT: if (rel && !found) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs derived from state; ack is the only path from ready
  always_comb begin
    out_valid = (state == GRANT);
    busy      = out_valid;
    ack       = (state == GRANT && ready) ? grant : '0;
  end

  // Grant registers, priority pointer, watchdog and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= '0;
      grant       <= '0;
      ptr         <= SELW'(N - 1);
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == IDLE || rel) && found) begin
        sel   <= win;
        grant <= {{(N-1){1'b0}}, 1'b1} << win;
        wd    <= '0;
      end else if (rel) begin
        grant <= '0;
      end else if (state == GRANT) begin
        wd <= wd + 8'd1;
      end
      if (rel) ptr <= sel;
      if (rel && !ready)  timeout_err <= 1'b1;
      else if (clr_err)   timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_mux_rr_sched;
  localparam int N = 31;
  localparam int SELW = 5;
  localparam int TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    en_mask = '1;
  logic            ready = 1'b0;
  logic            clr_err = 1'b0;
  logic [SELW-1:0] sel;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [N-1:0]    ack;
  logic            busy;
  logic            timeout_err;

  int errors = 0;
  int checks = 0;

  bit m_grant;
  int m_sel;
  int m_ptr;
  int m_wd;
  bit m_err;

  mux_rr_sched #(.N(N), .SELW(SELW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .en_mask(en_mask),
    .ready(ready), .clr_err(clr_err), .sel(sel), .grant(grant),
    .out_valid(out_valid), .ack(ack), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick(logic [N-1:0] c, int last);
    for (int k = 1; k <= N; k++) begin
      if (c[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_grant = 0;
    m_sel = 0;
    m_ptr = N - 1;
    m_wd = 0;
    m_err = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] c;
    int w;
    bit rel;
    if (reset) begin
      model_reset();
      return;
    end
    c = req & en_mask;
    rel = m_grant && (ready || m_wd == TIMEOUT - 1);
    if (rel && !ready) m_err = 1;
    else if (clr_err) m_err = 0;
    if (!m_grant) begin
      w = pick(c, m_ptr);
      if (w >= 0) begin
        m_grant = 1;
        m_sel = w;
        m_wd = 0;
      end
    end else if (rel) begin
      m_ptr = m_sel;
      c[m_sel] = 1'b0;
      w = pick(c, m_ptr);
      if (w >= 0) begin
        m_sel = w;
        m_wd = 0;
      end else begin
        m_grant = 0;
      end
    end else begin
      m_wd++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    en_mask = '1;
    ready = 1'b0;
    clr_err = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (sel !== 5'd0 || grant !== '0 || out_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_init sel=%0d grant=%h valid=%b err=%b want 0", sel, grant, out_valid, timeout_err);
    end
    reset = 1'b0;
    req = onehot(7);
    tick();
    checks++;
    if (sel !== 5'd7 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_grant sel=%0d valid=%b want 7/1", sel, out_valid);
    end
    ready = 1'b1;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (sel !== 5'd0 || grant !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || ack !== '0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_grant sel=%0d grant=%h valid=%b busy=%b ack=%h want all 0", sel, grant, out_valid, busy, ack);
    end
    req = onehot(0) | onehot(7);
    ready = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (sel !== 5'd0 || grant !== onehot(0) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant sel=%0d grant=%h want 0", sel, grant);
    end
  endtask

  task automatic test_lone();
    do_reset();
    req = onehot(12);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (out_valid !== (i % 2 == 0) || sel !== 5'd12) begin
        errors++;
        $display("FAIL lone_alt cyc=%0d valid=%b sel=%0d want %b/12", i, out_valid, sel, i % 2 == 0);
      end
      checks++;
      if (ack !== ((i % 2 == 0) ? onehot(12) : '0)) begin
        errors++;
        $display("FAIL lone_ack cyc=%0d ack=%h", i, ack);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = '1;
    ready = 1'b1;
    for (int i = 0; i < 33; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || sel !== SELW'(i % N)) begin
        errors++;
        $display("FAIL b2b cyc=%0d valid=%b sel=%0d want 1/%0d", i, out_valid, sel, i % N);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = onehot(30);
    ready = 1'b1;
    tick();
    checks++;
    if (sel !== 5'd30) begin
      errors++;
      $display("FAIL wrap_first sel=%0d want 30", sel);
    end
    req = onehot(30) | onehot(0);
    tick();
    checks++;
    if (sel !== 5'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero sel=%0d want 0", sel);
    end
    tick();
    checks++;
    if (sel !== 5'd30 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_back sel=%0d want 30", sel);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = onehot(5);
    ready = 1'b0;
    tick();
    req = onehot(5) | onehot(6);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || sel !== 5'd5 || ack !== '0 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL to_hold cyc=%0d valid=%b sel=%0d ack=%h err=%b", i, out_valid, sel, ack, timeout_err);
      end
    end
    tick();
    checks++;
    if (sel !== 5'd6 || out_valid !== 1'b1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_release sel=%0d valid=%b err=%b want 6/1/1", sel, out_valid, timeout_err);
    end
    ready = 1'b1;
    clr_err = 1'b1;
    tick();
    checks++;
    if (timeout_err !== 1'b0 || sel !== 5'd5) begin
      errors++;
      $display("FAIL to_clear err=%b sel=%0d want 0/5", timeout_err, sel);
    end
    req = onehot(5);
    ready = 1'b0;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL to_hold2 cyc=%0d valid=%b want 1", i, out_valid);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_set_wins valid=%b err=%b want 0/1", out_valid, timeout_err);
    end
    clr_err = 1'b0;
  endtask

  task automatic test_mask();
    do_reset();
    en_mask = ~onehot(3);
    req = onehot(3) | onehot(4);
    tick();
    checks++;
    if (sel !== 5'd4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mask_skip sel=%0d want 4", sel);
    end
    en_mask = '1;
    tick();
    checks++;
    if (sel !== 5'd4) begin
      errors++;
      $display("FAIL mask_stable sel=%0d want 4", sel);
    end
    ready = 1'b1;
    #1;
    checks++;
    if (ack !== onehot(4)) begin
      errors++;
      $display("FAIL mask_ack ack=%h want %h", ack, onehot(4));
    end
    tick();
    checks++;
    if (sel !== 5'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mask_enable sel=%0d want 3", sel);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] acked;
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ack;
    int pr;
    do_reset();
    for (int i = 0; i < 450; i++) begin
      pr = (i < 150) ? 80 : (i < 300) ? 4 : 50;
      acked = (m_grant && ready) ? onehot(m_sel) : '0;
      tick();
      req = (req & ~acked) | (N'($urandom) & N'($urandom) & N'($urandom));
      if (i % 25 == 0) en_mask = N'($urandom) | N'($urandom) | N'($urandom);
      ready = ($urandom_range(99) < pr);
      clr_err = ($urandom_range(9) == 0);
      #1;
      e_grant = m_grant ? onehot(m_sel) : '0;
      e_ack = (m_grant && ready) ? onehot(m_sel) : '0;
      checks++;
      if (sel !== SELW'(m_sel)) begin
        errors++;
        $display("FAIL rnd_sel cyc=%0d sel=%0d want %0d", i, sel, m_sel);
      end
      checks++;
      if (grant !== e_grant) begin
        errors++;
        $display("FAIL rnd_grant cyc=%0d grant=%h want %h", i, grant, e_grant);
      end
      checks++;
      if (out_valid !== m_grant || busy !== m_grant) begin
        errors++;
        $display("FAIL rnd_valid cyc=%0d valid=%b busy=%b want %b", i, out_valid, busy, m_grant);
      end
      checks++;
      if (ack !== e_ack) begin
        errors++;
        $display("FAIL rnd_ack cyc=%0d ack=%h want %h", i, ack, e_ack);
      end
      checks++;
      if (timeout_err !== m_err) begin
        errors++;
        $display("FAIL rnd_err cyc=%0d err=%b want %b", i, timeout_err, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lone();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that drives the 5-bit select of the 31-input, 2-bit-wide selection mux so 31 requesters share its single output. It sits beside the mux in the same top level. Each cycle it:
- picks one enabled, requesting source;
- drives `sel` for it;
- presents valid to the downstream consumer;
- acknowledges the source when the consumer accepts.

A watchdog releases grants the consumer never accepts.

## Interface
Parameters:
- `N`, 31, number of requesters (mux inputs 0..30); select code 31 is never driven.
- `SELW`, 5, width of `sel`.
- `TIMEOUT`, 15, maximum GRANT cycles without `ready` before forced release (range 1..255).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  N  per-source request; a source holds its bit high until its `ack` bit pulses.
- `en_mask`  input  N  per-source enable; a bit at 0 excludes that source from arbitration.
- `ready`  input  1  downstream accepts the mux output this cycle.
- `clr_err`  input  1  clears `timeout_err`.
- `sel`  output  SELW  select to the mux; registered.
- `grant`  output  N  one-hot copy of `sel` while in GRANT, otherwise 0; registered.
- `out_valid`  output  1  the mux output is valid for the consumer; high exactly in GRANT.
- `ack`  output  N  one-hot, combinational, `grant & {N{ready}}` in GRANT; a one-cycle pulse per accepted transfer.
- `busy`  output  1  equal to `out_valid`.
- `timeout_err`  output  1  sticky flag, set on a forced release.

## Operation
- FSM has two states.
  - IDLE: `out_valid`=0, `grant`=0, `sel` holds its last value.
  - GRANT: `out_valid`=1; `sel` and `grant` are stable for the whole state.
- Candidates = `req & en_mask`.
- Priority pointer `ptr` (5 bits) holds the last granted index. The search starts at `ptr+1`, wraps 30→0, and picks the first candidate.
- IDLE → GRANT: at any edge where the candidate set is non-empty, load `sel` and `grant` with the winner and clear the watchdog count.
- GRANT, handshake (`ready`=1):
  - `ack[sel]` is high that cycle.
  - At the edge, `ptr` ← `sel`.
  - Re-arbitrate over the candidates with bit `sel` masked off.
  - If a winner exists, stay in GRANT with the new `sel` (back-to-back, no bubble). Otherwise go to IDLE.
- GRANT, no `ready`: the watchdog count increments. When the count is TIMEOUT−1 and `ready`=0 at the edge, force a release:
  - no `ack`;
  - `ptr` ← `sel`;
  - `timeout_err` ← 1;
  - re-arbitrate exactly as for a handshake.
- `ready` and the timeout in the same cycle: the handshake wins; no error.
- `clr_err` and a forced release at the same edge: the set wins.
- `en_mask` or `req` changes during GRANT do not affect the current grant. They take effect at the next arbitration.
- A source dropping `req` before its `ack` is a protocol violation. The grant is held regardless.
- Index 31 is never a candidate; `sel` never equals 5'd31.

## Timing
- Reset, asynchronous and immediate, including mid-GRANT:
  - state IDLE;
  - `sel`=0, `grant`=0, `out_valid`=0, `busy`=0, `ack`=0;
  - `timeout_err`=0;
  - watchdog count 0;
  - `ptr`=30, so the first search starts at index 0.
- Grant latency: a candidate present before edge k while in IDLE gives `sel`, `grant` and `out_valid` valid after edge k (1 cycle).
- Throughput: one transfer per cycle while several candidates exist and `ready`=1.
- A lone persistent requester is granted every other cycle: GRANT, IDLE, GRANT, and so on.
- Forced release occurs after exactly TIMEOUT consecutive GRANT cycles without `ready`.
- `ack` is combinational from `ready`. There is no combinational path from `req` or `en_mask` to any output.

## Test plan
- Reset during GRANT on source 7: all outputs go to 0 immediately. After release, with `req[0]` and `req[7]` high, the first grant is `sel`=0.
- Only `req[12]` held high, `ready`=1: `sel`=12 and `out_valid` are high on alternating cycles. `ack[12]` pulses on each valid cycle.
- All `req` and `en_mask` bits =1, `ready`=1: `sel` sequence is 0,1,…,30,0 with no bubbles. `out_valid` stays high and `sel` is never 31.
- `ptr`=30 after granting 30; `req[30]`=1 and `req[0]`=1: the next grant is 0, then 30.
- `req[5]`=1, `ready`=0:
  - `out_valid` is high for exactly 15 cycles;
  - `timeout_err` rises and no `ack` occurs;
  - a pending `req[6]` is granted at the same edge;
  - `clr_err` then clears the flag.
- `en_mask[3]`=0 with `req[3]`=1 and `req[4]`=1: only 4 is granted. Setting `en_mask[3]`=1 during that grant gives `sel`=3 after the next release.
